// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: valid/ready handshake bundle between the round datapath and the MixColumns sequencer.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  modport master(output in_valid, in_bypass, in_state, out_ready, input in_ready, out_valid, out_state, busy);
  modport slave(input in_valid, in_bypass, in_state, out_ready, output in_ready, out_valid, out_state, busy);
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: AES MixColumns over a 128-bit state, one column per cycle through a shared column unit.
module matrix_mult (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module mix_columns_seq (
  input logic               clk,
  input logic               rst_n,
  mix_columns_seq_if.slave  bus_if
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]   state_q, state_d, col_q, col_d;
  logic [127:0] hold_q, hold_d, out_q, out_d;
  logic [31:0]  mm_out;
  // Column c lives at bits [127-32c -: 32], i.e. low bit 32*(3-c) = {~c, 5'b0}.
  matrix_mult u_mm (.col_i(hold_q[{~col_q, 5'b0} +: 32]), .col_o(mm_out));
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    hold_d  = hold_q;
    out_d   = out_q;
    if (state_q == IDLE && bus_if.in_valid) begin
      state_d = bus_if.in_bypass ? DONE : RUN;
      col_d   = 2'd0;
      hold_d  = bus_if.in_bypass ? hold_q : bus_if.in_state;
      out_d   = bus_if.in_bypass ? bus_if.in_state : out_q;
    end else if (state_q == RUN) begin
      out_d[{~col_q, 5'b0} +: 32] = mm_out;
      col_d   = col_q + 2'd1;
      state_d = (col_q == 2'd3) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = bus_if.out_ready ? IDLE : DONE;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end
  assign bus_if.in_ready  = state_q == IDLE;
  assign bus_if.out_valid = state_q == DONE;
  assign bus_if.busy      = state_q == RUN || state_q == DONE;
  assign bus_if.out_state = out_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: self-checking bench comparing the sequencer against a GF(2^8) matrix reference model.
module tb_mix_columns_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  mix_columns_seq_if bus();
  mix_columns_seq dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));
  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix: row r, input byte k uses coefficient {2,3,1,1}[(k-r) mod 4].
  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(s[127 - 32*c - 8*k -: 8], coef[(k - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic byp);
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = byp;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_bypass = 1'($urandom);
      bus.in_state  = rnd128();
      bus.out_ready = 1'($urandom);
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_state !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b busy=%b state=%h, want 0/0/0", bus.out_valid, bus.busy, bus.out_state);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_fips();
    int n;
    send(FIPS_IN, 1'b0);
    wait_done(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL fips_latency: got %0d edges want 4", n);
    end
    checks++;
    if (bus.out_state !== FIPS_OUT) begin
      errors++;
      $display("FAIL fips_state: got %h want %h", bus.out_state, FIPS_OUT);
    end
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_handoff: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_ignore_during_run();
    int n;
    send(V2_IN, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_bypass = 1'($urandom);
      bus.in_state  = rnd128();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL run_flags: got in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy);
      end
      step();
    end
    wait_done(n);
    bus.in_valid = 1'b0;
    checks++;
    if (n !== 1 || bus.out_state !== V2_OUT) begin
      errors++;
      $display("FAIL v2_state: got %h after %0d more edges, want %h after 1", bus.out_state, n, V2_OUT);
    end
    release_out();
  endtask

  task automatic test_bypass();
    int n;
    send(BYP_IN, 1'b1);
    wait_done(n);
    checks++;
    if (n !== 0 || bus.out_state !== BYP_IN) begin
      errors++;
      $display("FAIL bypass: got %h after %0d edges, want %h after 0", bus.out_state, n, BYP_IN);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] a = rnd128();
    logic [127:0] b = rnd128();
    send(a, 1'b0);
    wait_done(n);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_state !== mix_model(a)) begin
        errors++;
        $display("FAIL backpressure_hold: got valid=%b in_ready=%b state=%h want 1/0/%h", bus.out_valid, bus.in_ready, bus.out_state, mix_model(a));
      end
      step();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = b;
    bus.in_bypass = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 4 || bus.out_state !== mix_model(b)) begin
      errors++;
      $display("FAIL back_to_back: got %h after %0d edges, want %h after 4", bus.out_state, n, mix_model(b));
    end
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_done_handoff: got in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    send(rnd128(), 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_state !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: got valid=%b busy=%b in_ready=%b state=%h want 0/0/1/0", bus.out_valid, bus.busy, bus.in_ready, bus.out_state);
    end
    step();
    rst_n = 1'b1;
    step();
    send(FIPS_IN, 1'b0);
    wait_done(n);
    checks++;
    if (n !== 4 || bus.out_state !== FIPS_OUT) begin
      errors++;
      $display("FAIL post_reset_fips: got %h after %0d edges, want %h after 4", bus.out_state, n, FIPS_OUT);
    end
    release_out();
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 12; i++) begin
      logic [127:0] s = rnd128();
      logic byp = 1'($urandom_range(0, 3) == 0);
      logic [127:0] exp_s = byp ? s : mix_model(s);
      send(s, byp);
      wait_done(n);
      checks++;
      if (n !== (byp ? 0 : 4) || bus.out_state !== exp_s) begin
        errors++;
        $display("FAIL random_%0d: got %h after %0d edges, want %h (bypass=%b)", i, bus.out_state, n, exp_s, byp);
      end
      release_out();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips();
    test_ignore_during_run();
    test_bypass();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
